// File: rtl/fc_param_loader_if.sv
// Narrow valid/ready word stream carrying weights then biases into the loader.
interface fc_param_if #(
  parameter int ACTIV_BITS = 8
);
  logic [ACTIV_BITS-1:0] param_data;
  logic                  param_valid;
  logic                  param_ready;

  modport master (
    output param_data,
    output param_valid,
    input  param_ready
  );

  modport slave (
    input  param_data,
    input  param_valid,
    output param_ready
  );
endinterface

// File: rtl/fc_param_loader.sv
// Assembles a word stream into the FC layer's wide weight/bias buses and
// strobes the layer once each set is complete and stable.
//
// state  | meaning
// IDLE   | waiting for start; stream not accepted
// LOAD_W | accepting weight words, row-major (row*INPUT_SIZE + col)
// LOAD_B | accepting bias words, one per neuron
module fc_param_loader #(
  parameter int INPUT_SIZE  = 640,
  parameter int OUTPUT_SIZE = 64,
  parameter int ACTIV_BITS  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    bias_only,
  input  logic                                    abort,
  fc_param_if.slave                               pbus,
  output logic [OUTPUT_SIZE*INPUT_SIZE*ACTIV_BITS-1:0] weights_out,
  output logic [OUTPUT_SIZE*ACTIV_BITS-1:0]       biases_out,
  output logic                                    load_weights,
  output logic                                    load_biases,
  output logic                                    busy,
  output logic                                    done
);

  localparam int N_WEIGHTS = OUTPUT_SIZE * INPUT_SIZE;
  localparam int CNT_W     = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(N_WEIGHTS - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(OUTPUT_SIZE - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Abort masks ready so a word offered in the abort cycle is left with the source.
  assign pbus.param_ready = ((state == LOAD_W) || (state == LOAD_B)) && !abort;
  assign accept           = pbus.param_valid && pbus.param_ready;
  assign busy             = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      weights_out  <= '0;
      biases_out   <= '0;
      load_weights <= 1'b0;
      load_biases  <= 1'b0;
      done         <= 1'b0;
    end else begin
      load_weights <= 1'b0;
      load_biases  <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= bias_only ? LOAD_B : LOAD_W;
          end
        end
        LOAD_W: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            weights_out[cnt*ACTIV_BITS +: ACTIV_BITS] <= pbus.param_data;
            if (cnt == W_LAST) begin
              cnt          <= '0;
              state        <= LOAD_B;
              load_weights <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (abort) begin
            state <= IDLE;
          end else if (accept) begin
            biases_out[cnt*ACTIV_BITS +: ACTIV_BITS] <= pbus.param_data;
            if (cnt == B_LAST) begin
              cnt         <= '0;
              state       <= IDLE;
              load_biases <= 1'b1;
              done        <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fc_param_loader.md
Name: fc_param_loader

Overview:
- Write-side companion to the fully connected layer's parameter port.
- Accepts a narrow valid/ready word stream of weights and biases, for example from memory, SPI or a host bridge.
- Assembles the words into the layer's wide weights/biases buses.
- Asserts one-cycle load_weights / load_biases strobes so the layer captures a complete, stable parameter set.

Parameters:
- INPUT_SIZE, 640, inputs per neuron (columns of the weight matrix).
- OUTPUT_SIZE, 64, neurons (rows of the weight matrix, number of biases).
- ACTIV_BITS, 8, width of one weight/bias word.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a load sequence; sampled only in IDLE.
- bias_only  input  1  sampled with start; 1 = skip weights, load biases only.
- abort  input  1  terminate the sequence in progress.
- param_data  input  ACTIV_BITS  stream word.
- param_valid  input  1  param_data valid.
- param_ready  output  1  loader accepts the word this cycle.
- weights_out  output  OUTPUT_SIZE*INPUT_SIZE*ACTIV_BITS  to layer weights_in.
- biases_out  output  OUTPUT_SIZE*ACTIV_BITS  to layer biases_in.
- load_weights  output  1  one-cycle strobe to layer.
- load_biases  output  1  one-cycle strobe to layer.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse at sequence completion.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; word counter is 0.
  - weights_out=0, biases_out=0.
  - param_ready, load_weights, load_biases, busy, done all 0.
  - A reset mid-sequence discards partial data and emits no strobes.
- Handshake:
  - A word is accepted when param_valid && param_ready at a rising edge.
  - param_ready is combinational from state: 1 only in LOAD_W or LOAD_B.
  - param_data is don't-care when param_valid=0.
  - param_valid may gap arbitrarily; the counter advances only on accept.
- State machine (IDLE, LOAD_W, LOAD_B):
  - IDLE: on start=1, go to LOAD_B if bias_only=1, else LOAD_W; clear the counter.
  - start with param_valid in the same cycle accepts no word, because ready is 0 in IDLE.
  - busy=1 in every state except IDLE.
  - start while not IDLE is ignored.
  - LOAD_W:
    - Accepted word k (0..OUTPUT_SIZE*INPUT_SIZE-1) is written to weights_out[k*ACTIV_BITS +: ACTIV_BITS], so k = row*INPUT_SIZE + col.
    - On accepting the last weight: counter clears, state goes to LOAD_B, load_weights=1 on the following cycle, exactly one cycle.
  - LOAD_B:
    - Accepted word k (0..OUTPUT_SIZE-1) is written to biases_out[k*ACTIV_BITS +: ACTIV_BITS].
    - On accepting the last bias: state goes to IDLE; load_biases=1 and done=1 on the following cycle, each exactly one cycle.
    - busy is already 0 in that cycle.
- Abort:
  - abort=1 in LOAD_W or LOAD_B returns to IDLE next cycle with no strobes and no done.
  - A word presented in the abort cycle is not accepted: ready is forced to 0 when abort=1.
  - Partially written slices of weights_out/biases_out retain their values.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Output stability:
  - weights_out changes only on LOAD_W accepts; biases_out only on LOAD_B accepts.
  - Both are stable during and after their strobe cycle, so the layer captures consistent data.
  - A bias_only sequence leaves weights_out untouched.
- Widths:
  - Counter width is $clog2(OUTPUT_SIZE*INPUT_SIZE), minimum 1.
  - Terminal compare against OUTPUT_SIZE*INPUT_SIZE-1 in LOAD_W and OUTPUT_SIZE-1 in LOAD_B.
  - No wrap-around beyond the terminal count.
- Latency: last accept to strobe is 1 cycle. Back-to-back accepts sustain 1 word/cycle.

Test Plan (bench parameters INPUT_SIZE=3, OUTPUT_SIZE=2, ACTIV_BITS=8):
- Full load, continuous valid:
  - Stimulus: start, bias_only=0; stream 01,02,03,04,05,06,10,20.
  - Response: weights_out=48'h060504030201; load_weights one cycle after the 6th accept; biases_out=16'h2010.
  - Response: load_biases and done one cycle after the 8th accept; busy=0; exactly one pulse each.
- Gapped valid:
  - Stimulus: same data with param_valid low for 2 cycles between every word.
  - Response: identical final buses; strobes one cycle after the respective last accept; no extra accepts.
- Bias-only reload after the full load:
  - Stimulus: start, bias_only=1; stream AA,BB.
  - Response: biases_out=16'hBBAA; weights_out still 48'h060504030201; no load_weights; load_biases+done pulse.
- Abort mid-weights:
  - Stimulus: after 3 weights (11,22,33) assert abort together with param_valid.
  - Response: 4th word not accepted; IDLE next cycle; no strobes/done.
  - Response: weights_out low 24 bits = 33_22_11 and upper bits unchanged.
- Reset and ignored start:
  - Stimulus: start pulse during LOAD_B.
  - Response: ignored; sequence proceeds normally.
  - Stimulus: rst=1 mid-LOAD_W.
  - Response: all outputs 0 the next cycle and no strobes.
  - Stimulus: a subsequent full load.
  - Response: completes correctly.
- Start with simultaneous valid:
  - Stimulus: start and param_valid=1 (data 7F) in the same IDLE cycle.
  - Response: 7F not accepted; the first accepted word is the one presented in the next cycle.
